// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   size_e         : access size encoding as seen on req_size_i
//   state_e        : controller state encoding, with the St* constants below
//   is_misaligned  : alignment check for half/word accesses
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_e;

  typedef logic [2:0] state_e;

  localparam state_e StIdle  = 3'd0;
  localparam state_e StLoad  = 3'd1;
  localparam state_e StRmwRd = 3'd2;
  localparam state_e StStore = 3'd3;
  localparam state_e StResp  = 3'd4;

  // Bytes need no alignment; the illegal size is reported separately.
  function automatic logic is_misaligned(size_e size, logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extractor: picks the low byte/half/word of the RAM read window and
// sign- or zero-extends it to WIDTH.
//   rdata_i    : raw RAM read data (byte at the access address in [7:0])
//   size_i     : access size
//   unsigned_i : 1 = zero-extend, 0 = sign-extend (ignored for words)
//   ext_o      : extended result
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata_i,
  input  size_e            size_i,
  input  logic             unsigned_i,
  output logic [WIDTH-1:0] ext_o
);

  always_comb begin
    ext_o = rdata_i;
    case (size_i)
      SZ_B:    ext_o = {{(WIDTH-8){~unsigned_i & rdata_i[7]}}, rdata_i[7:0]};
      SZ_H:    ext_o = {{(WIDTH-16){~unsigned_i & rdata_i[15]}}, rdata_i[15:0]};
      default: ext_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the CPU memory stage and the data RAM.
// The RAM reads a 4-byte window at mem_addr_o combinationally and always
// writes all 4 bytes, so SB/SH do a read-modify-write through merge_q.
//   clk_i, rst_ni        : clock, async active-low reset
//   req_*                : CPU request (valid/ready handshake, accepted in idle only)
//   resp_*               : one-cycle response pulse with load data / error flag
//   mem_*                : RAM port; outputs come from flops or state decode only
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 17
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [1:0]       req_size_i,
  input  logic             req_unsigned_i,
  input  logic [WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             resp_valid_o,
  output logic [WIDTH-1:0] resp_rdata_o,
  output logic             resp_err_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  size_e               size_q;
  logic                unsigned_q;
  logic [WIDTH-1:0]    wdata_q;
  logic [WIDTH-1:0]    merge_q;
  logic [WIDTH-1:0]    rdata_q;
  logic                err_q;

  size_e               req_size;
  logic                accept;
  logic                req_err;
  logic [WIDTH-1:0]    load_ext;
  logic [WIDTH-1:0]    merge_d;
  logic                unused_addr_hi;

  assign req_size       = size_e'(req_size_i);
  assign accept         = req_valid_i & req_ready_o;
  assign req_err        = (req_size == SZ_ILL) | is_misaligned(req_size, req_addr_i[1:0]);
  // Upper address bits are outside the RAM and intentionally dropped.
  assign unused_addr_hi = ^req_addr_i[WIDTH-1:ADDR_W];

  lsu_load_ext #(
    .WIDTH (WIDTH)
  ) u_load_ext (
    .rdata_i    (mem_rdata_i),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .ext_o      (load_ext)
  );

  // Only SB/SH reach the merge; anything else keeps the read data.
  always_comb begin
    merge_d = mem_rdata_i;
    if (size_q == SZ_B) begin
      merge_d = {mem_rdata_i[WIDTH-1:8], wdata_q[7:0]};
    end else if (size_q == SZ_H) begin
      merge_d = {mem_rdata_i[WIDTH-1:16], wdata_q[15:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err) begin
            state_d = StResp;
          end else if (!req_we_i) begin
            state_d = StLoad;
          end else if (req_size == SZ_W) begin
            state_d = StStore;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLoad:  state_d = StResp;
      StRmwRd: state_d = StStore;
      StStore: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      size_q     <= SZ_B;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      merge_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= req_addr_i[ADDR_W-1:0];
        size_q     <= req_size;
        unsigned_q <= req_unsigned_i;
        wdata_q    <= req_wdata_i;
        rdata_q    <= '0;
        err_q      <= req_err;
      end
      if (state_q == StLoad) begin
        rdata_q <= load_ext;
      end
      if (state_q == StRmwRd) begin
        merge_q <= merge_d;
      end
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign resp_err_o   = (state_q == StResp) & err_q;
  assign resp_rdata_o = (state_q == StResp) ? rdata_q : '0;

  assign mem_we_o    = (state_q == StStore);
  assign mem_addr_o  = {{(WIDTH-ADDR_W){1'b0}}, addr_q};
  assign mem_wdata_o = (state_q != StStore) ? '0 : ((size_q == SZ_W) ? wdata_q : merge_q);

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-array RAM model (4-byte read
// window at the address, 4-byte write on negedge).
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram [0:131071];
  int          we_total = 0;
  int          resp_total = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic [32:0] resp_q [$];

  always #5 clk = ~clk;

  lsu_mem_ctrl #(
    .WIDTH  (32),
    .ADDR_W (17)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata)
  );

  logic [16:0] ra;
  assign ra = mem_addr[16:0];
  assign mem_rdata = {ram[17'(ra + 17'd3)], ram[17'(ra + 17'd2)],
                      ram[17'(ra + 17'd1)], ram[ra]};

  // RAM model and response/write monitor in one process.
  initial begin
    for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
    ram[17'h10000] = 8'hEF;
    ram[17'h10001] = 8'hBE;
    ram[17'h10002] = 8'hAD;
    ram[17'h10003] = 8'hDE;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        ram[ra]                 = mem_wdata[7:0];
        ram[17'(ra + 17'd1)]    = mem_wdata[15:8];
        ram[17'(ra + 17'd2)]    = mem_wdata[23:16];
        ram[17'(ra + 17'd3)]    = mem_wdata[31:24];
        we_total++;
        last_waddr = mem_addr;
        last_wdata = mem_wdata;
      end
      if (resp_valid) begin
        resp_total++;
        resp_q.push_back({resp_err, resp_rdata});
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request end to end: wait for ready, accept, measure latency to the
  // response pulse, then compare data, error flag and number of RAM writes.
  task automatic run(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_writes);
    int n;
    int lat;
    int we_base;
    @(negedge clk);
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    we_base      = we_total;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, resp_rdata, exp_rdata);
    check({tag, " err"}, {31'd0, resp_err}, {31'd0, exp_err});
    @(negedge clk);
    check({tag, " writes"}, 32'(we_total - we_base), 32'(exp_writes));
  endtask

  logic [1:0]  bb_size  [3] = '{2'b10, 2'b00, 2'b11};
  logic        bb_uns   [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] bb_addr  [3] = '{32'h0001_0000, 32'h0001_0001, 32'h0001_0000};
  logic [32:0] bb_exp   [3] = '{{1'b0, 32'hDEAD_77EF}, {1'b0, 32'h0000_0077},
                                {1'b1, 32'h0000_0000}};

  initial begin
    int idx;
    int cyc;
    int accepts;
    int rb;
    int we_base;
    int resp_base;
    logic rdy;

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    #2;
    check("reset ready", {31'd0, req_ready}, 32'd1);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset resp_err", {31'd0, resp_err}, 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset mem_we", {31'd0, mem_we}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Loads from EF BE AD DE at 0x10000.
    run("LW",  1'b0, 2'b10, 1'b0, 32'h0001_0000, '0, 2, 32'hDEAD_BEEF, 1'b0, 0);
    run("LB",  1'b0, 2'b00, 1'b0, 32'h0001_0003, '0, 2, 32'hFFFF_FFDE, 1'b0, 0);
    run("LBU", 1'b0, 2'b00, 1'b1, 32'h0001_0003, '0, 2, 32'h0000_00DE, 1'b0, 0);
    run("LH",  1'b0, 2'b01, 1'b0, 32'h0001_0002, '0, 2, 32'hFFFF_DEAD, 1'b0, 0);
    run("LHU", 1'b0, 2'b01, 1'b1, 32'h0001_0000, '0, 2, 32'h0000_BEEF, 1'b0, 0);

    // SB at 0x10001: window is BE AD DE 00, low byte replaced by 0x77.
    run("SB", 1'b1, 2'b00, 1'b0, 32'h0001_0001, 32'h1234_5677, 3, 32'd0, 1'b0, 1);
    check("SB waddr", last_waddr, 32'h0001_0001);
    check("SB wdata", last_wdata, 32'h00DE_AD77);
    run("LW after SB", 1'b0, 2'b10, 1'b0, 32'h0001_0000, '0, 2, 32'hDEAD_77EF, 1'b0, 0);

    run("SW", 1'b1, 2'b10, 1'b0, 32'h0001_0004, 32'hCAFE_F00D, 2, 32'd0, 1'b0, 1);
    check("SW wdata", last_wdata, 32'hCAFE_F00D);
    run("SH", 1'b1, 2'b01, 1'b0, 32'h0001_0004, 32'hAAAA_1234, 3, 32'd0, 1'b0, 1);
    check("SH wdata", last_wdata, 32'hCAFE_1234);
    run("LW after SH", 1'b0, 2'b10, 1'b0, 32'h0001_0004, '0, 2, 32'hCAFE_1234, 1'b0, 0);

    // Upper address bits are dropped: 0xFFFD0000 maps to RAM 0x10000.
    run("LW high addr", 1'b0, 2'b10, 1'b0, 32'hFFFD_0000, '0, 2, 32'hDEAD_77EF, 1'b0, 0);
    check("high addr mem_addr", mem_addr, 32'h0001_0000);

    // Errors: misaligned word/half, illegal size (also as a store).
    run("LW mis",  1'b0, 2'b10, 1'b0, 32'h0001_0002, '0, 1, 32'd0, 1'b1, 0);
    run("LH mis",  1'b0, 2'b01, 1'b0, 32'h0001_0001, '0, 1, 32'd0, 1'b1, 0);
    run("size 11", 1'b0, 2'b11, 1'b0, 32'h0001_0000, '0, 1, 32'd0, 1'b1, 0);
    run("SW mis",  1'b1, 2'b10, 1'b0, 32'h0001_0005, 32'h5555_5555, 1, 32'd0, 1'b1, 0);

    // Back-to-back with req_valid held high across three requests.
    rb        = resp_q.size();
    resp_base = resp_total;
    accepts   = 0;
    idx       = 0;
    cyc       = 0;
    @(negedge clk);
    req_we       = 1'b0;
    req_size     = bb_size[0];
    req_unsigned = bb_uns[0];
    req_addr     = bb_addr[0];
    req_valid    = 1'b1;
    while (idx < 3 && cyc < 40) begin
      rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        accepts++;
        idx++;
        if (idx < 3) begin
          req_size     = bb_size[idx];
          req_unsigned = bb_uns[idx];
          req_addr     = bb_addr[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b accepts", 32'(accepts), 32'd3);
    check("b2b responses", 32'(resp_total - resp_base), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (rb + k < resp_q.size()) begin
        check($sformatf("b2b resp%0d rdata", k), resp_q[rb+k][31:0], bb_exp[k][31:0]);
        check($sformatf("b2b resp%0d err", k), {31'd0, resp_q[rb+k][32]},
              {31'd0, bb_exp[k][32]});
      end
    end

    // Reset while in the STORE cycle, before its negedge.
    we_base   = we_total;
    resp_base = resp_total;
    @(negedge clk);
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h0001_0008;
    req_wdata = 32'h1122_3344;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst store mem_we before", {31'd0, mem_we}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst store mem_we after", {31'd0, mem_we}, 32'd0);
    check("rst store resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst ready after release", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("rst no write", 32'(we_total - we_base), 32'd0);
    check("rst no resp", 32'(resp_total - resp_base), 32'd0);
    check("rst ram unchanged", {ram[17'h1000B], ram[17'h1000A], ram[17'h10009], ram[17'h10008]},
          32'd0);
    run("LW after rst", 1'b0, 2'b10, 1'b0, 32'h0001_0008, '0, 2, 32'd0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
